// File: rtl/qr_skew_ctrl.sv
// Output deskew and frame control for a triangular QR systolic array.
// Optional frame counter output enabled by defining QR_SKEW_FRAME_CNT_EN.
module qr_skew_ctrl #(
    parameter int N_COL       = 4,
    parameter int DW          = 13,
    parameter int VALID_START = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  last_in,
    input  logic [N_COL*DW-1:0]   col_data_in,
    output logic [N_COL-1:0]      first_out,
    output logic [N_COL*DW-1:0]   data_out,
    output logic                  valid_out,
    output logic                  finish_out,
    output logic                  busy
`ifdef QR_SKEW_FRAME_CNT_EN
    ,
    output logic [7:0]            frame_cnt
`endif
);

    localparam int CNT_MAX = 2 * N_COL + 4;
    localparam int CW      = $clog2(2 * N_COL + 5);
    localparam int VLAT    = 2 * (N_COL - 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [VLAT-1:0] vsr_q;
    logic            raw_valid;

    assign cnt_inc   = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
    assign raw_valid = (state_q == RUN) && (int'(cnt_q) >= VALID_START) && !last_in;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (last_in) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = cnt_inc;
                if (vsr_q == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vsr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vsr_q   <= {vsr_q[VLAT-2:0], raw_valid};
        end
    end

    always_comb begin
        first_out = '0;
        for (int k = 0; k < N_COL; k++) begin
            first_out[k] = (state_q == RUN) && (int'(cnt_q) <= 2 * k + 1);
        end
    end

    assign valid_out  = vsr_q[VLAT-1];
    assign finish_out = (state_q == DONE);
    assign busy       = (state_q == RUN) || (state_q == DRAIN);

    // Lane k waits 2*(N_COL-1-k) cycles so every column lines up with lane 0.
    for (genvar k = 0; k < N_COL; k++) begin : g_lane
        localparam int D = 2 * (N_COL - 1 - k);
        logic [DW-1:0] out_q;

        if (D == 0) begin : g_direct
            always_ff @(posedge clk) begin
                if (reset) out_q <= '0;
                else       out_q <= col_data_in[k*DW +: DW];
            end
        end else begin : g_sr
            logic [DW-1:0] sr_q [D];

            // NOTE: the delay-line storage is reset too, so an abandoned frame leaves no data behind.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < D; i++) sr_q[i] <= '0;
                    out_q <= '0;
                end else begin
                    sr_q[0] <= col_data_in[k*DW +: DW];
                    for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
                    out_q <= sr_q[D-1];
                end
            end
        end

        assign data_out[k*DW +: DW] = out_q;
    end

`ifdef QR_SKEW_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                                     frame_cnt_q <= '0;
        else if (state_q == DRAIN && state_d == DONE)  frame_cnt_q <= frame_cnt_q + 8'd1;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
